// File: rtl/package_settings.sv
// Shared settings for the pulse-processing chain: sample widths used by the
// shaper stages and the configuration defaults and state type of the
// peak detector that follows the moving-average smoother.
package package_settings;

  // Width of the smoothed samples produced by the moving-average shaper.
  localparam int SIZE_SHAPER_DATA = 8;

  // Peak detector defaults: timestamp, dead-time counter and lost-pulse
  // counter widths.
  localparam int SIZE_PEAK_TIMESTAMP = 32;
  localparam int SIZE_PEAK_DEAD_TIME = 16;
  localparam int SIZE_PEAK_LOST      = 16;

  // Peak detector control states. IDLE must encode as zero because it is
  // the reset state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    REPORT = 2'd2,
    DEAD   = 2'd3
  } peak_state_t;

endpackage

// File: rtl/peak_detector.sv
// Pulse-height analyser fed by the moving-average smoother. It arms on a
// rising threshold crossing, tracks the pulse maximum, hands the result out
// through a valid/ready handshake, then waits out a programmable dead time.
// Crossings seen while a report is pending or during the dead time are
// counted as lost (saturating).
//
// Build option: define PEAK_DETECTOR_TIMESTAMP_EN to implement the sample
// timestamp counter and report the time of the maximum on peak_time.
// Without it the counter is removed and peak_time is tied to zero.
module peak_detector
  import package_settings::*;
#(
  parameter int DATA_WIDTH = SIZE_SHAPER_DATA,
  parameter int DEAD_WIDTH = SIZE_PEAK_DEAD_TIME,
  parameter int TS_WIDTH   = SIZE_PEAK_TIMESTAMP,
  parameter int LOST_WIDTH = SIZE_PEAK_LOST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic                  input_valid,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic [DEAD_WIDTH-1:0] dead_time,
  output logic [DATA_WIDTH-1:0] peak_amplitude,
  output logic [TS_WIDTH-1:0]   peak_time,
  output logic                  peak_valid,
  input  logic                  peak_ready,
  output logic [LOST_WIDTH-1:0] lost_count,
  output logic                  busy
);

  peak_state_t           state_q, state_d;
  logic                  above_q, above_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [DEAD_WIDTH-1:0] dead_q, dead_d;
  logic [LOST_WIDTH-1:0] lost_q, lost_d;

  logic above;
  logic rise;
  logic load_max;

  // Invalid cycles carry garbage, so "above" is qualified by input_valid and
  // a rising edge is only judged against the previous valid sample.
  assign above = input_valid && (input_data > threshold);
  assign rise  = above && !above_q;

  // The maximum (and its timestamp) is loaded when a pulse arms and whenever
  // a strictly larger sample arrives while tracking, so ties keep the first.
  assign load_max = ((state_q == IDLE)  && rise) ||
                    ((state_q == TRACK) && above && (input_data > max_q));

  // Next-state logic for the FSM, max tracker, dead-time and lost counters.
  always_comb begin
    state_d = state_q;
    above_d = above_q;
    max_d   = max_q;
    dead_d  = dead_q;
    lost_d  = lost_q;

    if (input_valid) begin
      above_d = above;
    end

    if (load_max) begin
      max_d = input_data;
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (input_valid && !above) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (peak_ready) begin
          dead_d  = '0;
          state_d = DEAD;
        end
      end
      DEAD: begin
        if (dead_q == dead_time) begin
          state_d = IDLE;
        end else if (input_valid) begin
          dead_d = dead_q + DEAD_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rise && ((state_q == REPORT) || (state_q == DEAD)) && (lost_q != '1)) begin
      lost_d = lost_q + LOST_WIDTH'(1);
    end
  end

  // Control and data registers; an asynchronous reset discards any pulse in
  // flight without counting it as lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      above_q <= 1'b0;
      max_q   <= '0;
      dead_q  <= '0;
      lost_q  <= '0;
    end else begin
      state_q <= state_d;
      above_q <= above_d;
      max_q   <= max_d;
      dead_q  <= dead_d;
      lost_q  <= lost_d;
    end
  end

`ifdef PEAK_DETECTOR_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [TS_WIDTH-1:0] max_ts_q, max_ts_d;

  // Timestamp advances once per valid sample and wraps; the timestamp of the
  // maximum follows the same load condition as the amplitude.
  always_comb begin
    ts_d     = ts_q;
    max_ts_d = max_ts_q;
    if (input_valid) begin
      ts_d = ts_q + TS_WIDTH'(1);
    end
    if (load_max) begin
      max_ts_d = ts_q;
    end
  end

  // Timestamp registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q     <= '0;
      max_ts_q <= '0;
    end else begin
      ts_q     <= ts_d;
      max_ts_q <= max_ts_d;
    end
  end

  assign peak_time = max_ts_q;
`else
  assign peak_time = '0;
`endif

  assign peak_amplitude = max_q;
  assign peak_valid     = (state_q == REPORT);
  assign busy           = (state_q != IDLE);
  assign lost_count     = lost_q;

endmodule

// File: tb/tb_peak_detector.sv
// Directed self-checking bench for peak_detector. A second instance with a
// 2-bit lost counter shares the stimulus to exercise saturation.
module tb_peak_detector;

  localparam int DW = 8;
  localparam int DTW = 16;
  localparam int TW = 32;
  localparam int LW = 16;

`ifdef PEAK_DETECTOR_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [DW-1:0]  input_data;
  logic           input_valid;
  logic [DW-1:0]  threshold;
  logic [DTW-1:0] dead_time;
  logic [DW-1:0]  peak_amplitude;
  logic [TW-1:0]  peak_time;
  logic           peak_valid;
  logic           peak_ready;
  logic [LW-1:0]  lost_count;
  logic           busy;

  logic [DW-1:0]  sat_amplitude;
  logic [TW-1:0]  sat_time;
  logic           sat_valid;
  logic [1:0]     sat_lost;
  logic           sat_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  peak_detector u_dut (
    .clk            (clk),
    .reset          (reset),
    .input_data     (input_data),
    .input_valid    (input_valid),
    .threshold      (threshold),
    .dead_time      (dead_time),
    .peak_amplitude (peak_amplitude),
    .peak_time      (peak_time),
    .peak_valid     (peak_valid),
    .peak_ready     (peak_ready),
    .lost_count     (lost_count),
    .busy           (busy)
  );

  peak_detector #(.LOST_WIDTH(2)) u_dut_sat (
    .clk            (clk),
    .reset          (reset),
    .input_data     (input_data),
    .input_valid    (input_valid),
    .threshold      (threshold),
    .dead_time      (dead_time),
    .peak_amplitude (sat_amplitude),
    .peak_time      (sat_time),
    .peak_valid     (sat_valid),
    .peak_ready     (peak_ready),
    .lost_count     (sat_lost),
    .busy           (sat_busy)
  );

  // Expected peak_time: the timestamp when the counter is built in, else 0.
  function automatic logic [31:0] expTime(input int t);
    return TS_EN ? 32'(t) : 32'd0;
  endfunction

  // Present one sample, let one rising edge pass, then settle 1 time unit.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r);
    input_valid = v;
    input_data  = d;
    peak_ready  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    input_valid = 1'b0;
    input_data  = '0;
    peak_ready  = 1'b0;
    reset       = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    threshold = 8'd40;
    dead_time = '0;
    doReset();

    // Reset state
    checkOutput("rst_valid", 32'(peak_valid), 32'd0);
    checkOutput("rst_amp",   32'(peak_amplitude), 32'd0);
    checkOutput("rst_time",  peak_time, 32'd0);
    checkOutput("rst_lost",  32'(lost_count), 32'd0);
    checkOutput("rst_busy",  32'(busy), 32'd0);

    // Single pulse: 0,10,50,120,80,30,0 with ready high
    applyStimulus(1, 0, 1);
    applyStimulus(1, 10, 1);
    checkOutput("sp_idle_busy", 32'(busy), 32'd0);
    applyStimulus(1, 50, 1);
    checkOutput("sp_arm_busy", 32'(busy), 32'd1);
    applyStimulus(1, 120, 1);
    applyStimulus(1, 80, 1);
    checkOutput("sp_track_valid", 32'(peak_valid), 32'd0);
    applyStimulus(1, 30, 1);
    checkOutput("sp_valid", 32'(peak_valid), 32'd1);
    checkOutput("sp_amp",   32'(peak_amplitude), 32'd120);
    checkOutput("sp_time",  peak_time, expTime(3));
    applyStimulus(1, 0, 1);
    checkOutput("sp_after_xfer_valid", 32'(peak_valid), 32'd0);
    checkOutput("sp_dead_busy", 32'(busy), 32'd1);
    applyStimulus(1, 0, 1);
    checkOutput("sp_idle_again", 32'(busy), 32'd0);
    checkOutput("sp_lost", 32'(lost_count), 32'd0);

    // Tie and equality: 40,41,90,90,20 with ready low
    doReset();
    applyStimulus(1, 40, 0);
    checkOutput("tie_eq_no_arm", 32'(busy), 32'd0);
    applyStimulus(1, 41, 0);
    checkOutput("tie_arm41", 32'(busy), 32'd1);
    applyStimulus(1, 90, 0);
    applyStimulus(1, 90, 0);
    applyStimulus(1, 20, 0);
    checkOutput("tie_valid", 32'(peak_valid), 32'd1);
    checkOutput("tie_amp",   32'(peak_amplitude), 32'd90);
    checkOutput("tie_time",  peak_time, expTime(2));

    // Back-pressure: 20 cycles ready low with a second pulse crossing
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, (i >= 5 && i <= 8) ? 8'd100 : 8'd10, 0);
      if (i == 10) begin
        checkOutput("bp_mid_amp", 32'(peak_amplitude), 32'd90);
      end
    end
    checkOutput("bp_held_valid", 32'(peak_valid), 32'd1);
    checkOutput("bp_held_amp",   32'(peak_amplitude), 32'd90);
    checkOutput("bp_held_time",  peak_time, expTime(2));
    checkOutput("bp_lost",       32'(lost_count), 32'd1);
    applyStimulus(1, 10, 1);
    checkOutput("bp_xfer_valid", 32'(peak_valid), 32'd0);
    applyStimulus(1, 10, 1);
    applyStimulus(1, 10, 1);
    checkOutput("bp_single_xfer", 32'(peak_valid), 32'd0);
    checkOutput("bp_idle", 32'(busy), 32'd0);

    // Dead time 5: crossing 3 samples after acceptance lost, 7 samples reported
    doReset();
    dead_time = 16'd5;
    applyStimulus(1, 10, 1);
    applyStimulus(1, 100, 1);
    applyStimulus(1, 10, 1);
    checkOutput("dt_first_amp",  32'(peak_amplitude), 32'd100);
    checkOutput("dt_first_time", peak_time, expTime(1));
    applyStimulus(1, 10, 1);
    checkOutput("dt_accept", 32'(peak_valid), 32'd0);
    applyStimulus(1, 10, 1);
    applyStimulus(1, 10, 1);
    applyStimulus(1, 100, 1);
    checkOutput("dt_lost_in_dead", 32'(lost_count), 32'd1);
    applyStimulus(1, 10, 1);
    applyStimulus(1, 10, 1);
    checkOutput("dt_still_dead", 32'(busy), 32'd1);
    applyStimulus(1, 10, 1);
    checkOutput("dt_end_idle", 32'(busy), 32'd0);
    applyStimulus(1, 77, 1);
    applyStimulus(1, 10, 1);
    checkOutput("dt_second_valid", 32'(peak_valid), 32'd1);
    checkOutput("dt_second_amp",   32'(peak_amplitude), 32'd77);
    checkOutput("dt_second_time",  peak_time, expTime(10));

    // Dead time 0: one-cycle DEAD, next crossing reported
    dead_time = 16'd0;
    applyStimulus(1, 10, 1);
    checkOutput("dt0_dead", 32'(busy), 32'd1);
    applyStimulus(1, 10, 1);
    checkOutput("dt0_idle", 32'(busy), 32'd0);
    applyStimulus(1, 60, 1);
    applyStimulus(1, 10, 1);
    checkOutput("dt0_valid", 32'(peak_valid), 32'd1);
    checkOutput("dt0_amp",   32'(peak_amplitude), 32'd60);
    checkOutput("dt0_time",  peak_time, expTime(14));
    checkOutput("dt0_lost",  32'(lost_count), 32'd1);
    applyStimulus(1, 10, 1);
    applyStimulus(1, 10, 1);

    // Invalid gaps carrying 255 inside and before a pulse
    doReset();
    applyStimulus(0, 255, 1);
    checkOutput("gap_no_arm", 32'(busy), 32'd0);
    applyStimulus(1, 10, 1);
    applyStimulus(1, 60, 1);
    applyStimulus(0, 255, 1);
    applyStimulus(1, 70, 1);
    applyStimulus(0, 255, 1);
    applyStimulus(0, 255, 1);
    applyStimulus(1, 65, 1);
    applyStimulus(0, 255, 1);
    checkOutput("gap_tracking", 32'(busy), 32'd1);
    applyStimulus(1, 10, 1);
    checkOutput("gap_valid", 32'(peak_valid), 32'd1);
    checkOutput("gap_amp",   32'(peak_amplitude), 32'd70);
    checkOutput("gap_time",  peak_time, expTime(2));
    applyStimulus(1, 10, 1);
    applyStimulus(1, 10, 1);

    // Asynchronous reset mid-TRACK
    applyStimulus(1, 100, 1);
    checkOutput("mid_track_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #2;
    checkOutput("async_busy",  32'(busy), 32'd0);
    checkOutput("async_amp",   32'(peak_amplitude), 32'd0);
    checkOutput("async_valid", 32'(peak_valid), 32'd0);
    checkOutput("async_time",  peak_time, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1, 10, 1);
    applyStimulus(1, 10, 1);
    checkOutput("post_rst_valid", 32'(peak_valid), 32'd0);
    checkOutput("post_rst_busy",  32'(busy), 32'd0);
    checkOutput("post_rst_lost",  32'(lost_count), 32'd0);

    // Saturation: report held, five more crossings lost
    applyStimulus(1, 100, 0);
    applyStimulus(1, 10, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 100, 0);
      applyStimulus(1, 10, 0);
    end
    checkOutput("sat_wide_lost",   32'(lost_count), 32'd5);
    checkOutput("sat_narrow_lost", 32'(sat_lost), 32'd3);
    checkOutput("sat_still_valid", 32'(sat_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/peak_detector.md
# peak_detector

Pulse-height analyser stage that sits directly downstream of the moving-average smoother and consumes its `output_data`/`enable` stream. It arms on a rising threshold crossing, tracks the maximum sample while the pulse stays above threshold, and reports amplitude and timestamp through a valid/ready handshake. It then enforces a programmable dead time and counts pulses lost to dead time or back-pressure.

## Interface
- `DATA_WIDTH`, default `SIZE_SHAPER_DATA`: sample width; unsigned samples.
- `DEAD_WIDTH`, default 16: width of the dead-time setting and counter.
- `TS_WIDTH`, default 32: timestamp width.
- `LOST_WIDTH`, default 16: width of the lost-pulse counter.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `input_data`  in  DATA_WIDTH  smoothed sample from the moving average.
- `input_valid`  in  1  sample qualifier; same signal that enables the moving-average output register.
- `threshold`  in  DATA_WIDTH  arming level; a sample must be strictly greater to count as above.
- `dead_time`  in  DEAD_WIDTH  number of valid samples ignored after a report is accepted.
- `peak_amplitude`  out  DATA_WIDTH  captured maximum.
- `peak_time`  out  TS_WIDTH  timestamp of the maximum sample.
- `peak_valid`  out  1  report available.
- `peak_ready`  in  1  consumer accepts the report.
- `lost_count`  out  LOST_WIDTH  saturating count of pulses not reported.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `above = input_valid && (input_data > threshold)`.
- `above_q` is a registered copy of the last valid sample's above flag.
- A rising crossing is `input_valid && above && !above_q`.
- Only valid samples update `above_q`, the timestamp, and the counters; invalid cycles are ignored entirely.
- The timestamp counter increments on every valid sample and wraps modulo 2^TS_WIDTH. The first valid sample after reset has timestamp 0.
- `threshold` and `dead_time` are sampled live every cycle; there is no shadowing.

State machine:
- **IDLE**: on a rising crossing, load `max = input_data` and `max_ts = ts`, then go to TRACK.
- **TRACK**:
  - Valid sample above threshold with `input_data > max`: update `max` and `max_ts`. Ties keep the first occurrence.
  - Valid sample not above threshold: go to REPORT.
- **REPORT**: `peak_valid = 1`. `peak_amplitude` and `peak_time` hold stable. On `peak_valid && peak_ready`, clear the dead counter and go to DEAD.
- **DEAD**: each valid sample increments the dead counter. When counter equals `dead_time`, go to IDLE. With `dead_time = 0`, DEAD lasts exactly one cycle.

Lost pulses:
- A rising crossing observed in REPORT or DEAD increments `lost_count`.
- `lost_count` saturates at all-ones and clears only on reset.

Reset values: all outputs and internal registers are 0, including `peak_amplitude`, `peak_time`, `peak_valid`, `lost_count`, `busy`, the timestamp, `above_q`, and the dead counter. State is IDLE.

## Timing
- **REPORT entry**: `peak_valid` rises on the clock edge after the falling (not-above) sample is presented, i.e. 1-cycle latency.
- **Handshake**: AXI-style.
  - `peak_valid`, once high, stays high with stable data until accepted.
  - `peak_ready` may be high before `peak_valid`.
  - The transfer occurs on the edge where both are high; `peak_valid` is low on the next cycle.
- **Simultaneous events**: if a rising crossing occurs in the same cycle as acceptance, it counts as lost and does not arm.
- **Re-arm after DEAD**: IDLE arms only on a rising crossing, so a pulse still above threshold when DEAD ends is not re-reported.
- **Asynchronous reset mid-pulse**: the in-flight pulse is discarded and not counted as lost.

## Configuration
- `PEAK_DETECTOR_TIMESTAMP_EN` defined: the timestamp counter and `max_ts` are implemented, and `peak_time` reports as described.
- Not defined: the counter and `max_ts` are removed, and `peak_time` is tied to 0. Ports are unchanged.

## Structure
- `package_settings` gains:
  - `SIZE_PEAK_TIMESTAMP` (32), `SIZE_PEAK_DEAD_TIME` (16), `SIZE_PEAK_LOST` (16), used as the parameter defaults.
  - The typedef `peak_state_t`, an enum `{IDLE, TRACK, REPORT, DEAD}`.
- There are no sub-modules; the single module holds the FSM, max tracker, and counters.

## Test plan
- **Single pulse**: threshold=40, valid samples 0,10,50,120,80,30,0, ready=1 → one report, amplitude=120, time=3, `lost_count`=0.
- **Tie and equality**: threshold=40, samples 40,41,90,90,20 → arms at 41 (40 does not arm); amplitude=90, time=2 (first of the tie).
- **Back-pressure**: ready=0 for 20 cycles while a second pulse crosses threshold → first report held stable; `lost_count`=1; after ready=1, exactly one transfer.
- **Dead time**: dead_time=5, pulse accepted, a new crossing 3 samples later → lost; a crossing 7 samples later → reported. Repeat with dead_time=0: the next crossing after the one-cycle DEAD is reported.
- **Invalid gaps**: insert `input_valid`=0 cycles carrying garbage samples of 255 into a pulse → no effect on max, timestamps, or arming.
- **Reset mid-TRACK and saturation**: reset asserted mid-TRACK → all outputs 0, state IDLE, no report after release. With LOST_WIDTH=2, force 5 lost pulses → `lost_count`=3.
